alu_cmd_sequencer: RTL and testbench

//  Command-side initiator for the registered 16-bit ALU (clk/reset_n, 4-bit op_code, a_in/b_in/cin -> y_out/cout).

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_cmd_sequencer_if.sv | 53 +++++
 rtl/alu_seq_fifo.sv | 49 ++++
 rtl/alu_cmd_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, opcode classification helpers and sequencer FSM encoding
// for the ALU command sequencer.
package alu_pkg;

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_ADC  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SBB  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_DEC  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } seq_state_e;

  // Opcodes whose carry/borrow out is architecturally meaningful.
  function automatic logic is_arith(input logic [3:0] op);
    return op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC};
  endfunction

  function automatic logic is_valid_op(input logic [3:0] op);
    return op inside {OP_PASS, OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC,
                      OP_AND, OP_XOR, OP_OR, OP_NOT};
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive, response and status signals of the ALU command sequencer.
// master = the sequencer itself, slave = its environment (producer, ALU, consumer).
interface alu_cmd_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned TAG_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              cmd_cin;
    logic              cmd_use_flag;
    logic [TAG_W-1:0]  cmd_tag;

    logic [OP_W-1:0]   alu_op_code;
    logic [DATA_W-1:0] alu_a_in;
    logic [DATA_W-1:0] alu_b_in;
    logic              alu_cin;
    logic [DATA_W-1:0] alu_y_out;
    logic              alu_cout;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_y;
    logic              rsp_cout;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;

    logic              flag_c;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_use_flag, cmd_tag,
        output cmd_ready,
        output alu_op_code, alu_a_in, alu_b_in, alu_cin,
        input  alu_y_out, alu_cout,
        output rsp_valid, rsp_y, rsp_cout, rsp_tag, rsp_err,
        input  rsp_ready,
        output flag_c, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_use_flag, cmd_tag,
        input  cmd_ready,
        input  alu_op_code, alu_a_in, alu_b_in, alu_cin,
        output alu_y_out, alu_cout,
        input  rsp_valid, rsp_y, rsp_cout, rsp_tag, rsp_err,
        output rsp_ready,
        input  flag_c, busy
    );
endinterface

// File: rtl/alu_seq_fifo.sv
// Command FIFO for the ALU sequencer: registered storage, wrapping pointers,
// count-based full/empty. Simultaneous push and pop leave the count unchanged.
module alu_seq_fifo #(
    parameter int unsigned WIDTH = 42,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // NOTE: storage is deliberately left out of reset; only pointers and count
    // define validity, and keeping the array reset-free lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues buffered, tagged commands one at a time to a registered ALU, captures
// the result after its 1-cycle latency and returns it; keeps the carry flag.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_cmd_sequencer_if.master  bus
);
    localparam int unsigned CMD_W = OP_W + 2 * DATA_W + 2 + TAG_W;

    seq_state_e r_state, w_state_next;

    logic [CMD_W-1:0]  w_fifo_rdata;
    logic              w_full, w_empty, w_push;
    logic              w_pop, w_capture, w_rsp_done, w_alu_clear;
    logic              w_flag_next, w_cin_sel;

    logic [OP_W-1:0]   w_head_op;
    logic [DATA_W-1:0] w_head_a, w_head_b;
    logic              w_head_cin, w_head_use_flag;
    logic [TAG_W-1:0]  w_head_tag;

    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_alu_a, r_alu_b;
    logic              r_alu_cin;
    logic [TAG_W-1:0]  r_tag;
    logic              r_flag_c;
    logic              r_rsp_valid, r_rsp_cout, r_rsp_err;
    logic [DATA_W-1:0] r_rsp_y;
    logic [TAG_W-1:0]  r_rsp_tag;

    assign w_push = bus.cmd_valid & bus.cmd_ready;

    alu_seq_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata ({bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_cin,
                   bus.cmd_use_flag, bus.cmd_tag}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_head_op, w_head_a, w_head_b, w_head_cin, w_head_use_flag,
            w_head_tag} = w_fifo_rdata;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values, independent of the order the always blocks execute in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // NOTE: defaulting every comb output first keeps these blocks latch-free.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (!w_empty) w_state_next = ST_ISSUE;
            ST_ISSUE:   w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = ST_RESP;
            ST_RESP:    if (bus.rsp_ready) w_state_next = w_empty ? ST_IDLE : ST_ISSUE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_rsp_done  = 1'b0;
        w_alu_clear = 1'b0;
        case (r_state)
            ST_IDLE:    w_pop = !w_empty;
            ST_CAPTURE: w_capture = 1'b1;
            ST_RESP: begin
                w_rsp_done  = bus.rsp_ready;
                w_pop       = bus.rsp_ready & !w_empty;
                w_alu_clear = bus.rsp_ready & w_empty;
            end
            default: ;
        endcase
    end

    // Forwarding the next flag value lets a carry written on the pop edge reach cin.
    assign w_flag_next = (w_capture && is_arith(r_alu_op)) ? bus.alu_cout : r_flag_c;
    assign w_cin_sel   = w_head_use_flag ? w_flag_next : w_head_cin;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_cin   <= 1'b0;
            r_tag       <= '0;
            r_flag_c    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_tag   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_alu_op  <= w_head_op;
                r_alu_a   <= w_head_a;
                r_alu_b   <= w_head_b;
                r_alu_cin <= w_cin_sel;
                r_tag     <= w_head_tag;
            end else if (w_alu_clear) begin
                r_alu_op  <= '0;
                r_alu_a   <= '0;
                r_alu_b   <= '0;
                r_alu_cin <= 1'b0;
            end

            r_flag_c <= w_flag_next;

            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_y     <= bus.alu_y_out;
                r_rsp_cout  <= bus.alu_cout;
                r_rsp_tag   <= r_tag;
                r_rsp_err   <= !is_valid_op(r_alu_op);
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready   = !w_full;
    assign bus.alu_op_code = r_alu_op;
    assign bus.alu_a_in    = r_alu_a;
    assign bus.alu_b_in    = r_alu_b;
    assign bus.alu_cin     = r_alu_cin;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_y       = r_rsp_y;
    assign bus.rsp_cout    = r_rsp_cout;
    assign bus.rsp_tag     = r_rsp_tag;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.flag_c      = r_flag_c;
    assign bus.busy        = (r_state != ST_IDLE) || !w_empty;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a registered 16-bit ALU model,
// a vector table for single commands and hand sequences for backpressure/reset.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.DATA_W(16), .OP_W(4), .TAG_W(4)) bus ();

    alu_cmd_sequencer #(.DATA_W(16), .OP_W(4), .DEPTH(4), .TAG_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    // Registered ALU in the environment: result one edge after operands are sampled.
    always @(posedge clk or negedge reset_n) begin
        logic [16:0] r;
        if (!reset_n) begin
            bus.alu_y_out <= '0;
            bus.alu_cout  <= 1'b0;
        end else begin
            case (bus.alu_op_code)
                OP_PASS: r = {1'b0, bus.alu_a_in};
                OP_ADD:  r = {1'b0, bus.alu_a_in} + {1'b0, bus.alu_b_in};
                OP_ADC:  r = {1'b0, bus.alu_a_in} + {1'b0, bus.alu_b_in} + 17'(bus.alu_cin);
                OP_SUB:  r = {1'b0, bus.alu_a_in} - {1'b0, bus.alu_b_in};
                OP_SBB:  r = {1'b0, bus.alu_a_in} - {1'b0, bus.alu_b_in} - 17'(bus.alu_cin);
                OP_INC:  r = {1'b0, bus.alu_a_in} + 17'd1;
                OP_DEC:  r = {1'b0, bus.alu_a_in} - 17'd1;
                OP_AND:  r = {1'b0, bus.alu_a_in & bus.alu_b_in};
                OP_XOR:  r = {1'b0, bus.alu_a_in ^ bus.alu_b_in};
                OP_OR:   r = {1'b0, bus.alu_a_in | bus.alu_b_in};
                OP_NOT:  r = {1'b0, ~bus.alu_a_in};
                default: r = '0;
            endcase
            bus.alu_y_out <= r[15:0];
            bus.alu_cout  <= r[16];
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        use_flag;
        logic [3:0]  tag;
        logic [15:0] exp_y;
        logic        exp_cout;
        logic        exp_err;
        logic        exp_flag;
        logic        exp_alu_cin;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        bus.cmd_op       = v.op;
        bus.cmd_a        = v.a;
        bus.cmd_b        = v.b;
        bus.cmd_cin      = v.cin;
        bus.cmd_use_flag = v.use_flag;
        bus.cmd_tag      = v.tag;
        bus.cmd_valid    = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check($sformatf("v%0d_alu_op", idx), 32'(bus.alu_op_code), 32'(v.op));
                check($sformatf("v%0d_alu_cin", idx), 32'(bus.alu_cin), 32'(v.exp_alu_cin));
            end
        end
        check($sformatf("v%0d_latency", idx), 32'(n), 32'd3);
        check($sformatf("v%0d_rsp_y", idx), 32'(bus.rsp_y), 32'(v.exp_y));
        check($sformatf("v%0d_rsp_cout", idx), 32'(bus.rsp_cout), 32'(v.exp_cout));
        check($sformatf("v%0d_rsp_tag", idx), 32'(bus.rsp_tag), 32'(v.tag));
        check($sformatf("v%0d_rsp_err", idx), 32'(bus.rsp_err), 32'(v.exp_err));
        check($sformatf("v%0d_flag_c", idx), 32'(bus.flag_c), 32'(v.exp_flag));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check($sformatf("v%0d_rsp_clear", idx), 32'(bus.rsp_valid), 32'd0);
        check($sformatf("v%0d_alu_idle", idx), 32'(bus.alu_a_in), 32'd0);
        check($sformatf("v%0d_busy", idx), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int acc, gap, n, seen;

        //            op       a         b        cin  uf  tag   exp_y    co  err fl  acin
        vecs[0]  = '{OP_ADD,  16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h3, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{OP_ADC,  16'h0001, 16'h0001, 1'b0, 1'b1, 4'h5, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{OP_SUB,  16'h0005, 16'h0007, 1'b0, 1'b0, 4'h6, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{OP_XOR,  16'h00FF, 16'h0F0F, 1'b0, 1'b0, 4'h7, 16'h0FF0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'b0111, 16'h1234, 16'h0000, 1'b0, 1'b0, 4'h8, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{OP_ADC,  16'h0010, 16'h0003, 1'b1, 1'b0, 4'h9, 16'h0014, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{OP_SBB,  16'h0000, 16'h0000, 1'b1, 1'b0, 4'hA, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{OP_ADC,  16'h7FFF, 16'h0000, 1'b0, 1'b1, 4'hB, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{OP_ADC,  16'h0001, 16'h0002, 1'b1, 1'b1, 4'hC, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_NOT,  16'h00F0, 16'h0000, 1'b0, 1'b0, 4'hD, 16'hFF0F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b1111, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 4'hE, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_cin = 1'b0;
        bus.cmd_use_flag = 1'b0;
        bus.cmd_tag = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_flag", 32'(bus.flag_c), 32'd0);
        check("idle_alu_op", 32'(bus.alu_op_code), 32'd0);
        check("idle_rsp_y", 32'(bus.rsp_y), 32'd0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Backpressure: 4 queued + 1 in flight, the sixth offer is refused.
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.cmd_op       = OP_PASS;
            bus.cmd_a        = 16'h0100 + 16'(i);
            bus.cmd_b        = 16'h0000;
            bus.cmd_cin      = 1'b0;
            bus.cmd_use_flag = 1'b0;
            bus.cmd_tag      = 4'(i);
            bus.cmd_valid    = 1'b1;
            if (bus.cmd_ready) acc++;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd5);
        check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        repeat (3) @(negedge clk);
        check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_hold_y", 32'(bus.rsp_y), 32'h0100);
        check("bp_hold_tag", 32'(bus.rsp_tag), 32'd0);
        check("bp_hold_ready", 32'(bus.cmd_ready), 32'd0);

        bus.rsp_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!bus.rsp_valid && gap < 20);
            check($sformatf("drain%0d_gap", k), 32'(gap), 32'd3);
            check($sformatf("drain%0d_y", k), 32'(bus.rsp_y), 32'h0100 + 32'(k));
            check($sformatf("drain%0d_tag", k), 32'(bus.rsp_tag), 32'(k));
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("drain_done_valid", 32'(bus.rsp_valid), 32'd0);
        check("drain_done_busy", 32'(bus.busy), 32'd0);
        check("drain_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Reset landing while the second command sits in CAPTURE.
        bus.rsp_ready    = 1'b1;
        bus.cmd_op       = OP_ADD;
        bus.cmd_a        = 16'hFFFF;
        bus.cmd_b        = 16'h0001;
        bus.cmd_tag      = 4'h1;
        bus.cmd_valid    = 1'b1;
        @(negedge clk);
        bus.cmd_op       = OP_XOR;
        bus.cmd_a        = 16'h00FF;
        bus.cmd_b        = 16'h0F0F;
        bus.cmd_tag      = 4'h2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_seq_first_tag", 32'(bus.rsp_tag), 32'h1);
        check("rst_seq_flag_set", 32'(bus.flag_c), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rst_flag", 32'(bus.flag_c), 32'd0);
        check("mid_rst_alu", {bus.alu_op_code, bus.alu_a_in[11:0], bus.alu_b_in, 3'b0, bus.alu_cin},
              32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("post_rst_no_stale", 32'(seen), 32'd0);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
